// File: rtl/mouse_tx_arbiter.sv
// rtl/mouse_tx_arbiter.sv - arbitrates 5-byte mouse packets and single aux bytes onto one byte sink
// Optional: define IDLE_REPORT_EN to capture and send events that have all four gesture flags clear.
module mouse_tx_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic       send_mouse_enable,
  input  logic       is_press,
  input  logic       is_release,
  input  logic       is_move,
  input  logic       is_scroll,
  input  logic [9:0] touch_h,
  input  logic [9:0] touch_v,
  input  logic       aux_req,
  input  logic [7:0] aux_data,
  output logic       aux_ack,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic [7:0] drop_count
);

  typedef enum logic [1:0] {IDLE, MOUSE, AUX} state_t;

  state_t      state;
  logic        pend_valid;
  logic [3:0]  pend_flags;
  logic [9:0]  pend_h;
  logic [9:0]  pend_v;
  logic [3:0]  seq;
  logic        last_mouse;
  logic        aux_req_q;
  logic [2:0]  idx;
  logic [7:0]  pkt [0:4];

  logic [3:0]  evt_flags;
  logic        evt_ok;
  logic        accept;
  logic        aux_pending;
  logic        grant_mouse;
  logic        grant_aux;
  logic [7:0]  b0, b1, b2, b3;

  assign evt_flags = {is_scroll, is_move, is_release, is_press};

`ifdef IDLE_REPORT_EN
  assign evt_ok = 1'b1;
`else
  assign evt_ok = |evt_flags;
`endif

  assign accept = send_mouse_enable & evt_ok;

  // Aux request goes through one register stage, like a mouse event through pending,
  // so requests raised on the same cycle meet in arbitration as a tie.
  assign aux_pending = aux_req & aux_req_q & ~aux_ack;

  always_comb begin
    grant_mouse = 1'b0;
    grant_aux   = 1'b0;
    if (state == IDLE) begin
      if (pend_valid && aux_pending) begin
        grant_mouse = ~last_mouse;
        grant_aux   = last_mouse;
      end else begin
        grant_mouse = pend_valid;
        grant_aux   = aux_pending;
      end
    end
  end

  assign b0 = {4'hA, pend_flags};
  assign b1 = pend_h[9:2];
  assign b2 = {pend_h[1:0], pend_v[9:4]};
  assign b3 = {pend_v[3:0], seq};

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      aux_ack    <= 1'b0;
      drop_count <= 8'h00;
      seq        <= 4'h0;
      pend_valid <= 1'b0;
      pend_flags <= 4'h0;
      pend_h     <= 10'h000;
      pend_v     <= 10'h000;
      last_mouse <= 1'b0;
      aux_req_q  <= 1'b0;
      idx        <= 3'd0;
    end else begin
      aux_req_q <= aux_req;
      aux_ack   <= 1'b0;

      // A capture on the snapshot edge refills pending without counting a drop.
      if (accept) begin
        pend_valid <= 1'b1;
        pend_flags <= evt_flags;
        pend_h     <= touch_h;
        pend_v     <= touch_v;
        if (pend_valid && !grant_mouse && drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end else if (grant_mouse) begin
        pend_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (grant_mouse) begin
            state      <= MOUSE;
            last_mouse <= 1'b1;
            pkt[0]     <= b0;
            pkt[1]     <= b1;
            pkt[2]     <= b2;
            pkt[3]     <= b3;
            pkt[4]     <= b0 ^ b1 ^ b2 ^ b3;
            idx        <= 3'd0;
            tx_valid   <= 1'b1;
            tx_data    <= b0;
          end else if (grant_aux) begin
            state      <= AUX;
            last_mouse <= 1'b0;
            tx_valid   <= 1'b1;
            tx_data    <= aux_data;
          end
        end
        MOUSE: begin
          if (tx_ready) begin
            if (idx == 3'd4) begin
              state    <= IDLE;
              tx_valid <= 1'b0;
              seq      <= seq + 4'd1;
            end else begin
              idx     <= idx + 3'd1;
              tx_data <= pkt[idx + 3'd1];
            end
          end
        end
        AUX: begin
          if (tx_ready) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            aux_ack  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_tx_arbiter.sv
// tb/tb_mouse_tx_arbiter.sv - scoreboard bench for mouse_tx_arbiter
module tb_mouse_tx_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       send_mouse_enable;
  logic       is_press, is_release, is_move, is_scroll;
  logic [9:0] touch_h, touch_v;
  logic       aux_req;
  logic [7:0] aux_data;
  logic       aux_ack;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [7:0] drop_count;

  always #5 clock = ~clock;

  mouse_tx_arbiter dut (
    .clock(clock), .reset(reset), .send_mouse_enable(send_mouse_enable),
    .is_press(is_press), .is_release(is_release), .is_move(is_move), .is_scroll(is_scroll),
    .touch_h(touch_h), .touch_v(touch_v), .aux_req(aux_req), .aux_data(aux_data),
    .aux_ack(aux_ack), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .drop_count(drop_count)
  );

  int         errors = 0;
  int         checks = 0;
  int         xfers = 0;
  int         acks = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_byte;
  logic [3:0] tb_seq = 4'h0;
  logic [7:0] tb_drops = 8'h00;

  function automatic logic [7:0] pkt_byte(input logic [3:0] f, input logic [9:0] h,
                                          input logic [9:0] v, input logic [3:0] s, input int i);
    logic [7:0] b [5];
    b[0] = {4'hA, f};
    b[1] = h[9:2];
    b[2] = {h[1:0], v[9:4]};
    b[3] = {v[3:0], s};
    b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
    return b[i];
  endfunction

  task automatic push_pkt(input logic [3:0] f, input logic [9:0] h, input logic [9:0] v);
    for (int i = 0; i < 5; i++) exp_q.push_back(pkt_byte(f, h, v, tb_seq, i));
    tb_seq = tb_seq + 4'd1;
  endtask

  always @(negedge clock) begin
    if (aux_ack) acks++;
    if (!reset && tx_valid && tx_ready) begin
      checks++;
      xfers++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte got=%h expected=none", tx_data);
      end else begin
        exp_byte = exp_q.pop_front();
        if (tx_data !== exp_byte) begin
          errors++;
          $display("FAIL byte_order got=%h expected=%h", tx_data, exp_byte);
        end
      end
    end
  end

  task automatic set_event(input logic [3:0] f, input logic [9:0] h, input logic [9:0] v);
    {is_scroll, is_move, is_release, is_press} = f;
    touch_h = h;
    touch_v = v;
    send_mouse_enable = 1'b1;
  endtask

  task automatic strobe(input logic [3:0] f, input logic [9:0] h, input logic [9:0] v);
    @(posedge clock); #1;
    set_event(f, h, v);
    @(posedge clock); #1;
    send_mouse_enable = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 300) begin
      @(negedge clock);
      if (aux_ack) aux_req = 1'b0;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || tx_valid) begin
      errors++;
      $display("FAIL %s_drain remaining=%0d expected=0", name, exp_q.size());
    end
  endtask

  task automatic check_drops(input string name);
    checks++;
    if (drop_count !== tb_drops) begin
      errors++;
      $display("FAIL %s_drop_count got=%0d expected=%0d", name, drop_count, tb_drops);
    end
  endtask

  task automatic wait_xfers(input int target, input string name);
    int n = 0;
    while (xfers < target && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (xfers < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got=%0d expected=%0d", name, xfers, target);
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    tb_seq = 4'h0;
    tb_drops = 8'h00;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks += 4;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b expected=0", tx_valid); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h expected=00", tx_data); end
    if (aux_ack !== 1'b0) begin errors++; $display("FAIL reset_aux_ack got=%b expected=0", aux_ack); end
    if (drop_count !== 8'h00) begin errors++; $display("FAIL reset_drop_count got=%h expected=00", drop_count); end
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_latency();
    logic [7:0] first;
    first = pkt_byte(4'b0001, 10'h3FF, 10'h001, tb_seq, 0);
    push_pkt(4'b0001, 10'h3FF, 10'h001);
    strobe(4'b0001, 10'h3FF, 10'h001);
    @(negedge clock);
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL latency_cycle1 got=%b expected=0", tx_valid); end
    @(posedge clock);
    @(negedge clock);
    checks += 2;
    if (tx_valid !== 1'b1) begin errors++; $display("FAIL latency_cycle2 got=%b expected=1", tx_valid); end
    if (tx_data !== first) begin errors++; $display("FAIL latency_b0 got=%h expected=%h", tx_data, first); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if (tx_valid !== 1'b1) begin errors++; $display("FAIL latency_consecutive got=%b expected=1", tx_valid); end
    end
    drain("latency");
    check_drops("latency");
  endtask

  task automatic test_stall();
    int base;
    logic [7:0] b2;
    base = xfers;
    b2 = pkt_byte(4'b0100, 10'h2B7, 10'h1C9, tb_seq, 2);
    push_pkt(4'b0100, 10'h2B7, 10'h1C9);
    strobe(4'b0100, 10'h2B7, 10'h1C9);
    wait_xfers(base + 2, "stall");
    tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks += 2;
      if (tx_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got=%b expected=1", tx_valid); end
      if (tx_data !== b2) begin errors++; $display("FAIL stall_hold got=%h expected=%h", tx_data, b2); end
    end
    @(posedge clock); #1 tx_ready = 1'b1;
    drain("stall");
  endtask

  task automatic test_arbitration();
    int ack_base;
    do_reset();
    ack_base = acks;
    push_pkt(4'b0010, 10'h155, 10'h0AA);
    exp_q.push_back(8'h5A);
    aux_data = 8'h5A;
    aux_req = 1'b1;
    set_event(4'b0010, 10'h155, 10'h0AA);
    @(posedge clock); #1;
    send_mouse_enable = 1'b0;
    drain("arb");
    repeat (3) @(negedge clock);
    checks += 2;
    if (acks - ack_base != 1) begin errors++; $display("FAIL arb_ack_pulses got=%0d expected=1", acks - ack_base); end
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL arb_regrant got=%b expected=0", tx_valid); end
  endtask

  task automatic test_overwrite();
    @(posedge clock); #1 tx_ready = 1'b0;
    push_pkt(4'b0001, 10'h011, 10'h022);
    strobe(4'b0001, 10'h011, 10'h022);
    @(posedge clock); #1;
    strobe(4'b0100, 10'h033, 10'h044);
    strobe(4'b1000, 10'h3C5, 10'h27E);
    push_pkt(4'b1000, 10'h3C5, 10'h27E);
    tb_drops = tb_drops + 8'd1;
    @(posedge clock); #1 tx_ready = 1'b1;
    drain("overwrite");
    check_drops("overwrite");
  endtask

  task automatic test_back_to_back();
    @(posedge clock); #1;
    push_pkt(4'b0011, 10'h101, 10'h202);
    set_event(4'b0011, 10'h101, 10'h202);
    @(posedge clock); #1;
    push_pkt(4'b0110, 10'h0F0, 10'h30F);
    set_event(4'b0110, 10'h0F0, 10'h30F);
    @(posedge clock); #1;
    send_mouse_enable = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clock);
      checks++;
      if (tx_valid !== (k != 7)) begin
        errors++;
        $display("FAIL b2b_gap_cycle%0d got=%b expected=%b", k, tx_valid, (k != 7));
      end
      @(posedge clock);
    end
    drain("b2b");
    check_drops("b2b");
  endtask

  task automatic test_reset_mid();
    int base;
    base = xfers;
    push_pkt(4'b0100, 10'h2AA, 10'h155);
    strobe(4'b0100, 10'h2AA, 10'h155);
    wait_xfers(base + 3, "reset_mid");
    reset = 1'b1;
    tx_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks += 2;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid got=%b expected=0", tx_valid); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_mid_data got=%h expected=00", tx_data); end
    exp_q.delete();
    tb_seq = 4'h0;
    tb_drops = 8'h00;
    @(posedge clock); #1;
    reset = 1'b0;
    tx_ready = 1'b1;
    push_pkt(4'b0010, 10'h123, 10'h2AB);
    strobe(4'b0010, 10'h123, 10'h2AB);
    drain("reset_mid");
    check_drops("reset_mid");
  endtask

  task automatic test_zero_flags();
`ifdef IDLE_REPORT_EN
    push_pkt(4'b0000, 10'h0C3, 10'h3A5);
    strobe(4'b0000, 10'h0C3, 10'h3A5);
    drain("zero_flags");
`else
    int seen = 0;
    strobe(4'b0000, 10'h0C3, 10'h3A5);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (tx_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL zero_flags_valid got=%0d expected=0", seen); end
`endif
    check_drops("zero_flags");
  endtask

  initial begin
    reset = 1'b1;
    send_mouse_enable = 1'b0;
    {is_scroll, is_move, is_release, is_press} = 4'b0000;
    touch_h = 10'h000;
    touch_v = 10'h000;
    aux_req = 1'b0;
    aux_data = 8'h00;
    tx_ready = 1'b1;
    test_reset();
    test_latency();
    test_stall();
    test_arbitration();
    test_overwrite();
    test_back_to_back();
    test_reset_mid();
    test_zero_flags();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
